// File: rtl/vga_line_fetch.sv
// vga_line_fetch
// ---------------------------------------------------------------------------------------------
// Pixel source that sits directly after the VGA timing generator. During horizontal blanking it
// fetches one 80-word row of a 160x120 RGB332 framebuffer into a line buffer. During the active
// area it drives the 4x-scaled pixel to the DAC, with the syncs delayed so they line up with rgb.
//
// Ports
//   clk_50MHz   in   system clock
//   clear       in   synchronous reset, active-high
//   pix_en      in   pixel tick; all video sampling happens on cycles with pix_en==1
//   h_count     in   [9:0] horizontal counter from the timing generator
//   v_count     in   [9:0] vertical counter from the timing generator
//   bright      in   visible-area flag
//   h_sync_in   in   raw hsync
//   v_sync_in   in   raw vsync
//   mem_req     out  read request, held with mem_addr stable until mem_ack
//   mem_addr    out  [ADDR_W-1:0] read word address
//   mem_ack     in   request accepted this cycle
//   mem_rvalid  in   mem_rdata valid this cycle (one per accepted request)
//   mem_rdata   in   [15:0] read data, [7:0] left pixel, [15:8] right pixel
//   rgb         out  [7:0] RGB332 pixel {r[2:0], g[2:0], b[1:0]}
//   h_sync      out  hsync aligned with rgb
//   v_sync      out  vsync aligned with rgb
//   underrun    out  sticky: a row fetch was still running when its active line began
// ---------------------------------------------------------------------------------------------
module vga_line_fetch #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_LAST   = 521,
    parameter int unsigned WORDS    = 80,
    parameter int unsigned ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] FB_BASE = 16'h8000
) (
    input  logic              clk_50MHz,
    input  logic              clear,
    input  logic              pix_en,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    input  logic              bright,
    input  logic              h_sync_in,
    input  logic              v_sync_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    output logic [7:0]        rgb,
    output logic              h_sync,
    output logic              v_sync,
    output logic              underrun
);

    // Word and row indices are 7 bits: up to 128 words per row and 128 framebuffer rows.
    localparam logic [9:0] HActiveC  = 10'(H_ACTIVE);
    localparam logic [9:0] VActiveC  = 10'(V_ACTIVE);
    localparam logic [9:0] VPrefetch = 10'(V_ACTIVE - 1);
    localparam logic [9:0] VLastC    = 10'(V_LAST);
    localparam logic [6:0] LastWord  = 7'(WORDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  idx_q, idx_d;
    logic [6:0]  row_q, row_d;
    logic        lb_we;

    logic [7:0]  rgb_q;
    logic        h_sync_q;
    logic        v_sync_q;
    logic        underrun_q;

    logic [15:0] linebuf [WORDS];

    // -----------------------------------------------------------------------------------------
    // Fetch trigger
    // -----------------------------------------------------------------------------------------
    logic       hblank_start;
    logic       prefetch_line;
    logic       last_line;
    logic       trigger;
    logic [6:0] trig_row;

    assign hblank_start  = pix_en && (h_count == HActiveC);
    // The last line of each group of four fetches the row displayed by the next group.
    assign prefetch_line = (v_count < VPrefetch) && (v_count[1:0] == 2'd3);
    assign last_line     = (v_count == VLastC);
    assign trigger       = hblank_start && (prefetch_line || last_line);

    // With v_count[1:0]==3, (v_count+1)>>2 equals v_count[8:2]+1, and no low bits are wasted.
    assign trig_row = last_line ? 7'd0 : (v_count[8:2] + 7'd1);

    // -----------------------------------------------------------------------------------------
    // Fetch FSM
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk_50MHz) begin
        if (clear) begin
            state_q <= StIdle;
            idx_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        lb_we   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A trigger while a fetch is still running is ignored simply by not
                // looking at it outside StIdle.
                if (trigger) begin
                    state_d = StReq;
                    row_d   = trig_row;
                    idx_d   = '0;
                end
            end
            StReq: begin
                if (mem_ack) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (mem_rvalid) begin
                    lb_we = 1'b1;
                    if (idx_q == LastWord) begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end else begin
                        state_d = StReq;
                        idx_d   = idx_q + 7'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Memory address: FB_BASE + row*80 + idx, with row*80 = (row<<6) + (row<<4). The sum wraps
    // at ADDR_W bits. The address is only presented while requesting, so it reads 0 otherwise.
    // -----------------------------------------------------------------------------------------
    logic [ADDR_W-1:0] row_off;
    logic [ADDR_W-1:0] word_addr;

    assign row_off   = ADDR_W'({row_q, 6'b0}) + ADDR_W'({row_q, 4'b0});
    assign word_addr = FB_BASE + row_off + ADDR_W'(idx_q);

    assign mem_req  = (state_q == StReq);
    assign mem_addr = mem_req ? word_addr : '0;

    // -----------------------------------------------------------------------------------------
    // Line buffer: written only during blanking, so the asynchronous read below never sees a
    // write to the word it is displaying in a legal frame. Contents are not reset.
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk_50MHz) begin
        if (lb_we) begin
            linebuf[idx_q] <= mem_rdata;
        end
    end

    logic [6:0]  word_sel;
    logic [15:0] rd_word;
    logic [7:0]  pix_byte;

    // Each 16-bit word covers 8 screen pixels: 2 framebuffer pixels, each repeated 4 times.
    assign word_sel = h_count[9:3];
    assign rd_word  = (word_sel <= LastWord) ? linebuf[word_sel] : 16'h0000;
    assign pix_byte = h_count[2] ? rd_word[15:8] : rd_word[7:0];

    // -----------------------------------------------------------------------------------------
    // Pixel output and sync delay: one pix_en tick of latency on rgb and both syncs.
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk_50MHz) begin
        if (clear) begin
            rgb_q    <= 8'h00;
            h_sync_q <= 1'b1;
            v_sync_q <= 1'b1;
        end else if (pix_en) begin
            rgb_q    <= bright ? pix_byte : 8'h00;
            h_sync_q <= h_sync_in;
            v_sync_q <= v_sync_in;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Underrun: the first line of a 4-line group starts while its row is still being fetched.
    // The fetch keeps going; stale words show until they are overwritten.
    // -----------------------------------------------------------------------------------------
    logic line_group_start;

    assign line_group_start = pix_en && (h_count == 10'd0) && (v_count < VActiveC) &&
                              (v_count[1:0] == 2'd0);

    always_ff @(posedge clk_50MHz) begin
        if (clear) begin
            underrun_q <= 1'b0;
        end else if (line_group_start && (state_q != StIdle)) begin
            underrun_q <= 1'b1;
        end
    end

    assign rgb      = rgb_q;
    assign h_sync   = h_sync_q;
    assign v_sync   = v_sync_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// tb_vga_line_fetch
// Directed bench for vga_line_fetch. A small memory responder answers requests with a
// configurable ack delay and logs every accepted address; read data is {tag, addr[7:0]}
// except the first framebuffer word, which holds 16'hE01C.
module tb_vga_line_fetch;

    logic        clk_50MHz;
    logic        clear;
    logic        pix_en;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        bright;
    logic        h_sync_in;
    logic        v_sync_in;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic [7:0]  rgb;
    logic        h_sync;
    logic        v_sync;
    logic        underrun;

    vga_line_fetch dut (
        .clk_50MHz  (clk_50MHz),
        .clear      (clear),
        .pix_en     (pix_en),
        .h_count    (h_count),
        .v_count    (v_count),
        .bright     (bright),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rgb        (rgb),
        .h_sync     (h_sync),
        .v_sync     (v_sync),
        .underrun   (underrun)
    );

    initial clk_50MHz = 1'b0;
    always #10 clk_50MHz = ~clk_50MHz;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------ memory responder
    logic [7:0]  tag;
    int          ack_delay;
    int          late_ack;
    int          ack_count = 0;
    int          ack_wait  = 0;
    logic        rv_pending = 1'b0;
    int          rv_wait   = 0;
    logic [15:0] rv_word   = 16'h0;
    logic [15:0] addr_log [1024];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == 16'h8000) ? 16'hE01C : {tag, a[7:0]};
    endfunction

    always @(negedge clk_50MHz) begin
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        if (rv_pending) begin
            if (rv_wait == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rv_word;
                rv_pending = 1'b0;
            end else begin
                rv_wait--;
            end
        end
        if (mem_req) begin
            if (ack_wait >= ack_delay) begin
                mem_ack = 1'b1;
                if (ack_count < 1024) addr_log[ack_count] = mem_addr;
                rv_word    = mem_word(mem_addr);
                rv_pending = 1'b1;
                rv_wait    = (ack_count == late_ack) ? 3 : 0;
                ack_count++;
                ack_wait   = 0;
            end else begin
                ack_wait++;
            end
        end else begin
            ack_wait = 0;
        end
    end

    // ------------------------------------------------------------------ stimulus helpers
    task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic b,
                       input logic hs, input logic vs);
        @(negedge clk_50MHz);
        h_count   = h;
        v_count   = v;
        bright    = b;
        h_sync_in = hs;
        v_sync_in = vs;
        pix_en    = 1'b1;
        @(posedge clk_50MHz);
        #1;
        pix_en = 1'b0;
    endtask

    task automatic wait_fetch(input string name, input int target);
        int n;
        n = 0;
        while ((ack_count < target || mem_req) && n < 4000) begin
            @(posedge clk_50MHz);
            #1;
            n++;
        end
        repeat (4) @(posedge clk_50MHz);
        #1;
        check_eq({name, "_count"}, ack_count, target);
        check_eq({name, "_req_low"}, {31'b0, mem_req}, 32'h0);
    endtask

    int base;

    initial begin
        clear = 1'b1; pix_en = 1'b0; h_count = '0; v_count = '0; bright = 1'b0;
        h_sync_in = 1'b1; v_sync_in = 1'b1; mem_ack = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = '0; tag = 8'h33; ack_delay = 0; late_ack = -1;

        // 1 reset
        repeat (2) @(posedge clk_50MHz);
        #1;
        clear = 1'b0;
        check_eq("rst_rgb", {24'b0, rgb}, 32'h00);
        check_eq("rst_hsync", {31'b0, h_sync}, 32'h1);
        check_eq("rst_vsync", {31'b0, v_sync}, 32'h1);
        check_eq("rst_req", {31'b0, mem_req}, 32'h0);
        check_eq("rst_addr", {16'b0, mem_addr}, 32'h0);
        check_eq("rst_underrun", {31'b0, underrun}, 32'h0);

        // 2 row 0 fetch on the last line of the frame
        base = ack_count;
        pix(10'd640, 10'd521, 1'b0, 1'b1, 1'b1);
        wait_fetch("row0", base + 80);
        check_eq("row0_addr0", {16'b0, addr_log[base]}, 32'h8000);
        check_eq("row0_addr1", {16'b0, addr_log[base + 1]}, 32'h8001);
        check_eq("row0_addr79", {16'b0, addr_log[base + 79]}, 32'h804F);
        pix(10'd0, 10'd0, 1'b1, 1'b0, 1'b1);
        check_eq("row0_no_underrun", {31'b0, underrun}, 32'h0);

        // 3 pixel map and sync lag (the tick above was h=0, hs=0, vs=1)
        check_eq("pix_h0", {24'b0, rgb}, 32'h1C);
        check_eq("sync_h_lag", {31'b0, h_sync}, 32'h0);
        check_eq("sync_v_lag", {31'b0, v_sync}, 32'h1);
        @(negedge clk_50MHz);
        h_count = 10'd4; h_sync_in = 1'b1; v_sync_in = 1'b0;
        repeat (2) @(posedge clk_50MHz);
        #1;
        check_eq("hold_rgb", {24'b0, rgb}, 32'h1C);
        check_eq("hold_hsync", {31'b0, h_sync}, 32'h0);
        pix(10'd3, 10'd0, 1'b1, 1'b1, 1'b0);
        check_eq("pix_h3", {24'b0, rgb}, 32'h1C);
        check_eq("sync_h_follow", {31'b0, h_sync}, 32'h1);
        check_eq("sync_v_follow", {31'b0, v_sync}, 32'h0);
        pix(10'd4, 10'd0, 1'b1, 1'b1, 1'b1);
        check_eq("pix_h4", {24'b0, rgb}, 32'hE0);
        pix(10'd7, 10'd0, 1'b1, 1'b1, 1'b1);
        check_eq("pix_h7", {24'b0, rgb}, 32'hE0);
        pix(10'd8, 10'd0, 1'b1, 1'b1, 1'b1);
        check_eq("pix_h8", {24'b0, rgb}, 32'h01);
        pix(10'd12, 10'd0, 1'b1, 1'b1, 1'b1);
        check_eq("pix_h12", {24'b0, rgb}, 32'h33);
        pix(10'd320, 10'd0, 1'b1, 1'b1, 1'b1);
        check_eq("pix_h320", {24'b0, rgb}, 32'h28);
        pix(10'd324, 10'd0, 1'b1, 1'b1, 1'b1);
        check_eq("pix_h324", {24'b0, rgb}, 32'h33);
        pix(10'd4, 10'd0, 1'b0, 1'b1, 1'b1);
        check_eq("pix_dark", {24'b0, rgb}, 32'h00);

        // 4 row addressing
        base = ack_count;
        pix(10'd640, 10'd3, 1'b0, 1'b1, 1'b1);
        wait_fetch("row1", base + 80);
        check_eq("row1_addr0", {16'b0, addr_log[base]}, 32'h8050);
        check_eq("row1_addr79", {16'b0, addr_log[base + 79]}, 32'h809F);
        base = ack_count;
        pix(10'd640, 10'd475, 1'b0, 1'b1, 1'b1);
        wait_fetch("row119", base + 80);
        check_eq("row119_addr0", {16'b0, addr_log[base]}, 32'hA530);
        base = ack_count;
        pix(10'd640, 10'd479, 1'b0, 1'b1, 1'b1);
        pix(10'd639, 10'd3, 1'b0, 1'b1, 1'b1);
        pix(10'd640, 10'd477, 1'b0, 1'b1, 1'b1);
        repeat (10) @(posedge clk_50MHz);
        #1;
        check_eq("nofetch_req", {31'b0, mem_req}, 32'h0);
        check_eq("nofetch_count", ack_count, base);

        // 5 slow memory: underrun at the start of the line group, fetch still completes;
        // a second trigger during the fetch must not restart it
        ack_delay = 10;
        base = ack_count;
        pix(10'd640, 10'd3, 1'b0, 1'b1, 1'b1);
        pix(10'd0, 10'd4, 1'b1, 1'b1, 1'b1);
        check_eq("slow_underrun", {31'b0, underrun}, 32'h1);
        pix(10'd640, 10'd521, 1'b0, 1'b1, 1'b1);
        wait_fetch("slow", base + 80);
        check_eq("slow_addr0", {16'b0, addr_log[base]}, 32'h8050);
        check_eq("slow_addr79", {16'b0, addr_log[base + 79]}, 32'h809F);
        check_eq("slow_underrun_sticky", {31'b0, underrun}, 32'h1);
        ack_delay = 0;

        // 6 reset mid-fetch with a late rvalid pending for word 40
        tag  = 8'h44;
        base = ack_count;
        pix(10'd640, 10'd521, 1'b0, 1'b1, 1'b1);
        wait_fetch("pre6", base + 80);
        tag      = 8'h55;
        base     = ack_count;
        late_ack = base + 40;
        pix(10'd640, 10'd521, 1'b0, 1'b1, 1'b1);
        begin
            int n;
            n = 0;
            while (ack_count < base + 41 && n < 1000) begin
                @(posedge clk_50MHz);
                #1;
                n++;
            end
        end
        check_eq("mid_acks", ack_count, base + 41);
        clear = 1'b1;
        @(posedge clk_50MHz);
        #1;
        clear = 1'b0;
        check_eq("mid_req", {31'b0, mem_req}, 32'h0);
        check_eq("mid_addr", {16'b0, mem_addr}, 32'h0);
        check_eq("mid_underrun", {31'b0, underrun}, 32'h0);
        check_eq("mid_hsync", {31'b0, h_sync}, 32'h1);
        repeat (8) @(posedge clk_50MHz);
        #1;
        check_eq("mid_no_more_acks", ack_count, base + 41);
        pix(10'd324, 10'd0, 1'b1, 1'b1, 1'b1);
        check_eq("mid_late_ignored", {24'b0, rgb}, 32'h44);
        pix(10'd12, 10'd0, 1'b1, 1'b1, 1'b1);
        check_eq("mid_new_word1", {24'b0, rgb}, 32'h55);
        late_ack = -1;
        tag      = 8'h66;
        base     = ack_count;
        pix(10'd640, 10'd521, 1'b0, 1'b1, 1'b1);
        wait_fetch("restart", base + 80);
        check_eq("restart_addr0", {16'b0, addr_log[base]}, 32'h8000);
        pix(10'd324, 10'd0, 1'b1, 1'b1, 1'b1);
        check_eq("restart_word40", {24'b0, rgb}, 32'h66);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
